// File: rtl/miriscv_lsu_split_if.sv
// Data-memory bus between the LSU (master) and the memory port (slave):
// req/gnt accepts a beat, rvalid returns its response in order.
interface miriscv_lsu_split_if #(
  parameter int DATA_W = 32
) ();
  localparam int BYTES = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              we;
  logic [BYTES-1:0]  be;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/miriscv_lsu_split.sv
// Load/store unit: req/gnt/rvalid bus handshake, misaligned accesses split
// into two aligned beats (or flagged as errors when splitting is disabled).
module miriscv_lsu_split #(
  parameter int DATA_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              lsu_stall_req_o,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_err_o,
  miriscv_lsu_split_if.master dbus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_e;
  state_e r_state, w_next;

  logic [31:0]       r_addr;
  logic [2:0]        r_size;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata, r_beat0, r_rdata;

  // decode of the incoming request, used only when it is captured
  logic [3:0]       w_in_n;
  logic [OFS_W-1:0] w_in_msk;
  logic             w_in_legal, w_in_mis, w_in_err;

  assign w_in_n   = 4'd1 << lsu_size_i[1:0];
  assign w_in_msk = OFS_W'(w_in_n - 4'd1);
  assign w_in_mis = |(lsu_addr_i[OFS_W-1:0] & w_in_msk);
  assign w_in_err = !w_in_legal || (w_in_mis && !MISALIGNED_EN);

  always_comb begin
    case (lsu_size_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_in_legal = 1'b1;
      3'b011:                                 w_in_legal = (DATA_W == 64);
      default:                                w_in_legal = 1'b0;
    endcase
  end

  logic [OFS_W-1:0]    w_ofs;
  logic [3:0]          w_n;
  logic                w_split, w_msb, w_sign, w_load_done;
  logic [2*BYTES-1:0]  w_be2;
  logic [31:0]         w_base;
  logic [DATA_W-1:0]   w_wdata, w_shift, w_ext;
  logic [2*DATA_W-1:0] w_merged;

  assign w_ofs   = r_addr[OFS_W-1:0];
  assign w_n     = 4'd1 << r_size[1:0];
  assign w_split = (5'(w_ofs) + 5'(w_n)) > 5'(BYTES);
  assign w_be2   = (2*BYTES)'((32'd1 << w_n) - 32'd1) << w_ofs;
  assign w_base  = {r_addr[31:OFS_W], {OFS_W{1'b0}}};
  // rotate so each store byte lands on its lane in either beat
  assign w_wdata = DATA_W'(({r_wdata, r_wdata} << {w_ofs, 3'b000}) >> DATA_W);

  assign w_merged = (r_state == S_WAIT1) ? {dbus.rdata, r_beat0}
                                         : {{DATA_W{1'b0}}, dbus.rdata};
  assign w_shift  = DATA_W'(w_merged >> {w_ofs, 3'b000});

  always_comb begin
    case (r_size[1:0])
      2'd0:    w_msb = w_shift[7];
      2'd1:    w_msb = w_shift[15];
      2'd2:    w_msb = w_shift[31];
      default: w_msb = w_shift[DATA_W-1];
    endcase
    w_sign = w_msb & ~r_size[2];
    w_ext  = '0;
    for (int i = 0; i < DATA_W; i++)
      w_ext[i] = (i < 8 * int'(w_n)) ? w_shift[i] : w_sign;
  end

  assign w_load_done = !r_we && dbus.rvalid &&
                       ((r_state == S_WAIT0 && !w_split) || r_state == S_WAIT1);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    dbus.req   = 1'b0;
    dbus.we    = 1'b0;
    dbus.be    = '0;
    dbus.addr  = '0;
    dbus.wdata = '0;
    case (r_state)
      S_IDLE:  if (lsu_req_i) w_next = w_in_err ? S_DONE : S_REQ0;
      S_REQ0: begin
        dbus.req   = 1'b1;
        dbus.we    = r_we;
        dbus.be    = w_be2[BYTES-1:0];
        dbus.addr  = w_base;
        dbus.wdata = w_wdata;
        if (dbus.gnt) w_next = S_WAIT0;
      end
      S_WAIT0: if (dbus.rvalid) w_next = w_split ? S_REQ1 : S_DONE;
      S_REQ1: begin
        dbus.req   = 1'b1;
        dbus.we    = r_we;
        dbus.be    = w_be2[2*BYTES-1:BYTES];
        dbus.addr  = w_base + 32'(BYTES);
        dbus.wdata = w_wdata;
        if (dbus.gnt) w_next = S_WAIT1;
      end
      S_WAIT1: if (dbus.rvalid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_beat0 <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && lsu_req_i) begin
        r_addr  <= lsu_addr_i;
        r_size  <= lsu_size_i;
        r_we    <= lsu_we_i;
        r_wdata <= lsu_data_i;
        r_err   <= w_in_err;
      end
      if (r_state == S_WAIT0 && dbus.rvalid) r_beat0 <= dbus.rdata;
      if (w_load_done) r_rdata <= w_ext;
    end
  end

  assign lsu_data_o      = r_rdata;
  assign lsu_err_o       = r_err & (r_state == S_DONE);
  assign lsu_stall_req_o = lsu_req_i & (r_state != S_DONE);
endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Randomized bench: byte-addressed memory behind a delayed-gnt/rvalid responder,
// loads and stores checked against a byte-level reference model.
module tb_miriscv_lsu_split;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  miriscv_lsu_split_if #(.DATA_W(DW)) bus0 ();
  miriscv_lsu_split_if #(.DATA_W(DW)) bus1 ();

  logic          req0, we0, stall0, err0;
  logic [2:0]    sz0;
  logic [31:0]   addr0, wd0, rd0;
  logic          req1, we1, stall1, err1;
  logic [2:0]    sz1;
  logic [31:0]   addr1, wd1, rd1;

  miriscv_lsu_split #(.DATA_W(DW), .MISALIGNED_EN(1'b1)) u_dut0 (
    .clk_i(clk), .arstn_i(rst_n), .lsu_req_i(req0), .lsu_we_i(we0), .lsu_size_i(sz0),
    .lsu_addr_i(addr0), .lsu_data_i(wd0), .lsu_stall_req_o(stall0), .lsu_data_o(rd0),
    .lsu_err_o(err0), .dbus(bus0));

  miriscv_lsu_split #(.DATA_W(DW), .MISALIGNED_EN(1'b0)) u_dut1 (
    .clk_i(clk), .arstn_i(rst_n), .lsu_req_i(req1), .lsu_we_i(we1), .lsu_size_i(sz1),
    .lsu_addr_i(addr1), .lsu_data_i(wd1), .lsu_stall_req_o(stall1), .lsu_data_o(rd1),
    .lsu_err_o(err1), .dbus(bus1));

  logic [7:0] mem   [logic [31:0]];
  logic [7:0] ref_m [logic [31:0]];
  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] dflt(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : dflt(a);
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem[a] = b;
    ref_m[a] = b;
  endtask

  // little-endian gather of n bytes, then sign/zero extension
  function automatic logic [31:0] model_load(logic [2:0] sz, logic [31:0] a);
    int n;
    logic [63:0] v;
    n = 1 << sz[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + i);
    if (!sz[2] && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v[31:0];
  endfunction

  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int gmax, input int rmax, input int exp_lat,
                        input logic illegal, output logic err_o, output logic [31:0] data_o);
    int n, nb, bi, cyc, gcnt, rcnt;
    bit pend, was_pend, done;
    logic [31:0] w0, b, ewd, baddr, bwd;
    logic [31:0] eaddr [2];
    logic [3:0]  ebe [2];
    logic [3:0]  bben;
    logic        bwe;
    n = 1 << sz[1:0];
    w0 = {a[31:2], 2'b00};
    eaddr[0] = w0;
    eaddr[1] = w0 + 32'd4;
    ebe[0] = '0;
    ebe[1] = '0;
    for (int i = 0; i < n; i++) begin
      b = a + i;
      if ({b[31:2], 2'b00} == w0) ebe[0][b[1:0]] = 1'b1;
      else                        ebe[1][b[1:0]] = 1'b1;
    end
    nb = illegal ? 0 : ((ebe[1] != 0) ? 2 : 1);
    for (int j = 0; j < 4; j++) ewd[8*j +: 8] = wd[8*((j - int'(a[1:0])) & 3) +: 8];
    baddr = '0; bwd = '0; bben = '0; bwe = 1'b0;

    @(negedge clk);
    req0 = 1'b1; we0 = we; sz0 = sz; addr0 = a; wd0 = wd;
    bi = 0; cyc = 0; pend = 0; done = 0; rcnt = 0;
    gcnt = $urandom_range(gmax, 0);
    while (!done && cyc < 100) begin
      #1;
      bus0.gnt = 1'b0;
      bus0.rvalid = 1'b0;
      bus0.rdata = $urandom;
      if (!stall0) done = 1;
      else begin
        was_pend = pend;
        if (pend) begin
          if (rcnt == 0) begin
            bus0.rvalid = 1'b1;
            pend = 0;
            for (int j = 0; j < 4; j++) begin
              if (bwe && bben[j]) mem[baddr + j] = bwd[8*j +: 8];
              bus0.rdata[8*j +: 8] = mem_rd(baddr + j);
            end
          end else rcnt--;
        end
        if (bus0.req) begin
          if (was_pend) check("beat_while_outstanding", 1, 0);
          else if (gcnt == 0) begin
            bus0.gnt = 1'b1;
            pend = 1;
            rcnt = $urandom_range(rmax, 0);
            baddr = bus0.addr; bben = bus0.be; bwe = bus0.we; bwd = bus0.wdata;
            if (bi < 2) begin
              check("beat_addr", baddr, eaddr[bi]);
              check("beat_be", bben, ebe[bi]);
              check("beat_we", bwe, we);
              if (we) check("beat_wdata", bwd, ewd);
            end
            bi++;
            gcnt = $urandom_range(gmax, 0);
          end else gcnt--;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) check("completion_timeout", 0, 1);
    if (exp_lat >= 0) check("latency", cyc, exp_lat);
    check("beat_count", bi, nb);
    check("bus_idle", {bus0.req, bus0.we, bus0.be, bus0.addr}, '0);
    check("bus_wdata_idle", bus0.wdata, '0);
    err_o = err0;
    data_o = rd0;
    bus0.gnt = 1'b0;
    bus0.rvalid = 1'b0;
    req0 = 1'b0;
  endtask

  task automatic do_acc(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int gmax, input int rmax, input int lat,
                        output logic [31:0] d);
    logic e, illegal;
    logic [31:0] prev;
    illegal = (sz == 3'b011) || (sz[2:1] == 2'b11);
    prev = rd0;
    access(we, sz, a, wd, gmax, rmax, lat, illegal, e, d);
    check("err", e, illegal);
    if (illegal || we) check("data_hold", d, prev);
    else               check("load_data", d, model_load(sz, a));
    if (we && !illegal)
      for (int i = 0; i < (1 << sz[1:0]); i++) begin
        check("store_byte", mem_rd(a + i), wd[8*i +: 8]);
        ref_m[a + i] = wd[8*i +: 8];
      end
  endtask

  initial begin
    logic [31:0] d;
    logic [2:0]  szt [10];
    logic [2:0]  sz;
    logic [31:0] a;
    logic        we;
    szt = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    req0 = 0; we0 = 0; sz0 = 0; addr0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; sz1 = 0; addr1 = 0; wd1 = 0;
    bus0.gnt = 0; bus0.rvalid = 0; bus0.rdata = 0;
    bus1.gnt = 0; bus1.rvalid = 0; bus1.rdata = 0;
    poke(32'h100, 8'hFF); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h80);
    poke(32'h202, 8'hAA); poke(32'h203, 8'hBB); poke(32'h204, 8'hCC); poke(32'h205, 8'hDD);

    repeat (2) @(negedge clk);
    check("rst_bus", {bus0.req, bus0.we, bus0.be, bus0.addr}, '0);
    check("rst_wdata", bus0.wdata, '0);
    check("rst_core", {stall0, err0, rd0}, '0);
    rst_n = 1'b1;

    do_acc(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 3, d);
    check("lw_0x100", d, 32'h8000_00FF);
    do_acc(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 3, d);
    check("lb_0x103", d, 32'hFFFF_FF80);
    do_acc(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 3, d);
    check("lbu_0x103", d, 32'h0000_0080);
    do_acc(1'b0, 3'b010, 32'h202, 32'h0, 0, 0, 5, d);
    check("lw_split", d, 32'hDDCC_BBAA);
    do_acc(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_1234, 0, 0, 5, d);
    do_acc(1'b0, 3'b011, 32'h300, 32'h0, 0, 0, 1, d);

    // splitting disabled: misaligned store completes with error, no bus beat
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; sz1 = 3'b010; addr1 = 32'h101; wd1 = 32'hDEAD_BEEF;
    #1;
    check("noalign_c0", {stall1, bus1.req, err1}, 3'b100);
    @(negedge clk); #1;
    check("noalign_c1", {stall1, bus1.req, err1}, 3'b001);
    req1 = 1'b0;
    @(negedge clk); #1;
    check("noalign_c2", {bus1.req, err1}, 2'b00);
    check("noalign_data", rd1, 32'h0);

    // grant withheld, then reset lands while waiting for rvalid
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; sz0 = 3'b010; addr0 = 32'h100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("req_held", {bus0.req, bus0.addr}, {1'b1, 32'h100});
    end
    bus0.gnt = 1'b1;
    @(negedge clk); #1;
    bus0.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_drops_req", bus0.req, 1'b0);
    req0 = 1'b0;
    #1;
    check("rst_stall", stall0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus0.rvalid = 1'b1;
    bus0.rdata = 32'h1234_5678;
    @(negedge clk); #1;
    bus0.rvalid = 1'b0;
    check("late_rvalid_ignored", {bus0.req, stall0, rd0}, '0);
    do_acc(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 3, d);
    check("lw_after_rst", d, 32'h8000_00FF);

    for (int k = 0; k < 60; k++) begin
      sz = szt[$urandom_range(9, 0)];
      we = 1'($urandom_range(1, 0));
      if (we && sz[2]) sz = {1'b0, sz[1:0]};
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFF8 + $urandom_range(7, 0);
      else                           a = 32'h300 + $urandom_range(31, 0);
      do_acc(we, sz, a, $urandom, 3, 3, -1, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
